// File: rtl/gpio_irq_pkg.sv
// Shared register map, DEB_CFG field layout and read-as-zero mask helpers
// for the GPIO interrupt controller.
package gpio_irq_pkg;

  localparam logic [2:0] REG_LEVEL   = 3'd0;
  localparam logic [2:0] REG_IRQ_EN  = 3'd1;
  localparam logic [2:0] REG_RISE_EN = 3'd2;
  localparam logic [2:0] REG_FALL_EN = 3'd3;
  localparam logic [2:0] REG_PENDING = 3'd4;
  localparam logic [2:0] REG_DEB_CFG = 3'd5;

  localparam int DEB_P_LSB = 0;
  localparam int DEB_T_LSB = 12;
  localparam int DEB_T_W   = 4;

  // Mask with one bit set for each present channel, starting at bit 0.
  function automatic logic [15:0] ch_mask(input int unsigned n);
    logic [15:0] m;
    m = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (i < n) m[i] = 1'b1;
      else       m[i] = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [15:0] deb_mask(input int unsigned p_bits, input int unsigned t_bits);
    logic [15:0] m;
    m = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (i < DEB_P_LSB + p_bits)                      m[i] = 1'b1;
      else if (i >= DEB_T_LSB && i < DEB_T_LSB + t_bits) m[i] = 1'b1;
      else                                             m[i] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_deb_chan.sv
// One GPIO input channel: synchroniser, tick-based debouncer, LEVEL flop and
// registered rise/fall event pulses aligned with the LEVEL change.
module gpio_deb_chan
  import gpio_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_BITS    = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_pin,
  input  logic                i_tick,
  input  logic [DEB_BITS-1:0] i_thr,
  input  logic                i_rise_en,
  input  logic                i_fall_en,
  output logic                o_level,
  output logic                o_rise,
  output logic                o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DEB_BITS-1:0]    r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;

  logic                   w_s;
  logic                   w_level_nxt;
  logic [DEB_BITS-1:0]    w_cnt_nxt;
  logic [DEB_BITS:0]      w_cnt_inc;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc = {1'b0, r_cnt} + (DEB_BITS+1)'(1);

  // Next debounce state; the extra increment bit keeps the count from wrapping.
  always_comb begin
    w_level_nxt = r_level;
    w_cnt_nxt   = r_cnt;
    if (i_thr == {DEB_BITS{1'b0}}) begin
      w_level_nxt = w_s;
      w_cnt_nxt   = {DEB_BITS{1'b0}};
    end else if (w_s == r_level) begin
      w_cnt_nxt   = {DEB_BITS{1'b0}};
    end else if (i_tick) begin
      if (w_cnt_inc >= {1'b0, i_thr}) begin
        w_level_nxt = w_s;
        w_cnt_nxt   = {DEB_BITS{1'b0}};
      end else begin
        w_cnt_nxt   = w_cnt_inc[DEB_BITS-1:0];
      end
    end else begin
      w_cnt_nxt   = r_cnt;
    end
  end

  // Synchroniser, counter, LEVEL and edge pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= {SYNC_STAGES{1'b0}};
      r_cnt   <= {DEB_BITS{1'b0}};
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= i_rise_en &  w_level_nxt & ~r_level;
      r_fall  <= i_fall_en & ~w_level_nxt &  r_level;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO input / interrupt controller: shared debounce prescaler, register
// file, sticky W1C pending bits, masked IRQ and registered read port.
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter int N_CH        = 6,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_BITS    = 4,
  parameter int PRESC_BITS  = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_gpio_in,
  input  logic [2:0]      i_addr,
  input  logic [15:0]     i_data_in,
  output logic [15:0]     o_data_out,
  input  logic            i_wr,
  input  logic            i_rd,
  output logic            o_irq,
  output logic [N_CH-1:0] o_level
);

  localparam logic [15:0] W_MASK = ch_mask(N_CH);
  localparam logic [15:0] D_MASK = deb_mask(PRESC_BITS, DEB_BITS);

  logic [15:0]           r_irq_en;
  logic [15:0]           r_rise_en;
  logic [15:0]           r_fall_en;
  logic [15:0]           r_deb_cfg;
  logic [15:0]           r_pend;
  logic [15:0]           r_dout;
  logic                  r_irq;
  logic [PRESC_BITS-1:0] r_presc;

  logic                  w_tick;
  logic                  w_cfg_wr;
  logic [15:0]           w_clr;
  logic [15:0]           w_set;
  logic [15:0]           w_level16;
  logic [15:0]           w_rd_data;
  logic [N_CH-1:0]       w_level;
  logic [N_CH-1:0]       w_rise;
  logic [N_CH-1:0]       w_fall;

  assign w_tick   = (r_presc == r_deb_cfg[DEB_P_LSB +: PRESC_BITS]);
  assign w_cfg_wr = i_wr && (i_addr == REG_DEB_CFG);

  // Prescaler restarts on every DEB_CFG write so the new period applies at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= {PRESC_BITS{1'b0}};
    end else if (w_cfg_wr || w_tick) begin
      r_presc <= {PRESC_BITS{1'b0}};
    end else begin
      r_presc <= r_presc + PRESC_BITS'(1);
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      gpio_deb_chan #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_BITS   (DEB_BITS)
      ) u_chan (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_pin    (i_gpio_in[g]),
        .i_tick   (w_tick),
        .i_thr    (r_deb_cfg[DEB_T_LSB +: DEB_BITS]),
        .i_rise_en(r_rise_en[g]),
        .i_fall_en(r_fall_en[g]),
        .o_level  (w_level[g]),
        .o_rise   (w_rise[g]),
        .o_fall   (w_fall[g])
      );
    end
  endgenerate

  // Widen per-channel vectors to the 16-bit register view.
  always_comb begin
    w_set                = 16'h0000;
    w_level16            = 16'h0000;
    w_set[N_CH-1:0]      = w_rise | w_fall;
    w_level16[N_CH-1:0]  = w_level;
  end

  assign w_clr = (i_wr && (i_addr == REG_PENDING)) ? i_data_in : 16'h0000;

  // Control register writes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_irq_en  <= 16'h0000;
      r_rise_en <= 16'h0000;
      r_fall_en <= 16'h0000;
      r_deb_cfg <= 16'h0000;
    end else if (i_wr) begin
      case (i_addr)
        REG_IRQ_EN:  r_irq_en  <= i_data_in & W_MASK;
        REG_RISE_EN: r_rise_en <= i_data_in & W_MASK;
        REG_FALL_EN: r_fall_en <= i_data_in & W_MASK;
        REG_DEB_CFG: r_deb_cfg <= i_data_in & D_MASK;
        default:     r_irq_en  <= r_irq_en;
      endcase
    end else begin
      r_irq_en <= r_irq_en;
    end
  end

  // Sticky pending bits; a same-cycle set overrides the W1C clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend <= 16'h0000;
      r_irq  <= 1'b0;
    end else begin
      r_pend <= ((r_pend & ~w_clr) | w_set) & W_MASK;
      r_irq  <= |(r_pend & r_irq_en);
    end
  end

  // Read data selection.
  always_comb begin
    w_rd_data = 16'h0000;
    case (i_addr)
      REG_LEVEL:   w_rd_data = w_level16;
      REG_IRQ_EN:  w_rd_data = r_irq_en;
      REG_RISE_EN: w_rd_data = r_rise_en;
      REG_FALL_EN: w_rd_data = r_fall_en;
      REG_PENDING: w_rd_data = r_pend;
      REG_DEB_CFG: w_rd_data = r_deb_cfg;
      default:     w_rd_data = 16'h0000;
    endcase
  end

  // Read port holds its value between strobes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dout <= 16'h0000;
    end else if (i_rd) begin
      r_dout <= w_rd_data;
    end else begin
      r_dout <= r_dout;
    end
  end

  assign o_data_out = r_dout;
  assign o_irq      = r_irq;
  assign o_level    = w_level;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed self-checking bench for gpio_irq_ctrl (16 channels, 10 MHz clock):
// register table plus hand-written latency, debounce and pending sequences.
`timescale 1ns/1ps
module tb_gpio_irq_ctrl;
  import gpio_irq_pkg::*;

  localparam int NCH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] gpio;
  logic [2:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        wr;
  logic        rd;
  logic        irq;
  logic [15:0] level;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_irq_ctrl #(.N_CH(NCH), .SYNC_STAGES(2), .DEB_BITS(4), .PRESC_BITS(8)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_gpio_in (gpio),
    .i_addr    (addr),
    .i_data_in (din),
    .o_data_out(dout),
    .i_wr      (wr),
    .i_rd      (rd),
    .o_irq     (irq),
    .o_level   (level)
  );

  always #50 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  a;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; din = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = dout;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  vec_t        vecs[13];
  logic [15:0] rv;
  int          t_lvl;

  initial begin
    rst = 1'b1; gpio = 16'h0000; addr = 3'd0; din = 16'h0000; wr = 1'b0; rd = 1'b0;
    vecs[0]  = '{REG_IRQ_EN,  16'hFFFF, 16'hFFFF};
    vecs[1]  = '{REG_RISE_EN, 16'hA5A5, 16'hA5A5};
    vecs[2]  = '{REG_FALL_EN, 16'h5A5A, 16'h5A5A};
    vecs[3]  = '{REG_DEB_CFG, 16'hFFFF, 16'hF0FF};
    vecs[4]  = '{REG_DEB_CFG, 16'h3009, 16'h3009};
    vecs[5]  = '{REG_LEVEL,   16'h1234, 16'h0000};
    vecs[6]  = '{3'd6,        16'hFFFF, 16'h0000};
    vecs[7]  = '{3'd7,        16'hFFFF, 16'h0000};
    vecs[8]  = '{REG_PENDING, 16'hFFFF, 16'h0000};
    vecs[9]  = '{REG_IRQ_EN,  16'h0000, 16'h0000};
    vecs[10] = '{REG_RISE_EN, 16'h0000, 16'h0000};
    vecs[11] = '{REG_FALL_EN, 16'h0000, 16'h0000};
    vecs[12] = '{REG_DEB_CFG, 16'h0000, 16'h0000};

    cyc(3);
    chk("reset_irq", {15'h0000, irq}, 16'h0000);
    chk("reset_dout", dout, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      reg_rd(3'(i), rv);
      chk($sformatf("reset_read%0d", i), rv, 16'h0000);
    end
    chk("reset_irq_after", {15'h0000, irq}, 16'h0000);

    for (int i = 0; i < 13; i++) begin
      reg_wr(vecs[i].a, vecs[i].wd);
      reg_rd(vecs[i].a, rv);
      chk($sformatf("regvec%0d", i), rv, vecs[i].exp);
    end

    // Pin-to-IRQ latency with bypass debounce.
    reg_wr(REG_RISE_EN, 16'h0001);
    reg_wr(REG_IRQ_EN, 16'h0001);
    gpio[0] = 1'b1;
    cyc(4);
    chk("lat_irq_at4", {15'h0000, irq}, 16'h0000);
    cyc(1);
    chk("lat_irq_at5", {15'h0000, irq}, 16'h0001);
    gpio[0] = 1'b0;
    cyc(6);
    reg_rd(REG_PENDING, rv);
    chk("lat_pending", rv, 16'h0001);
    reg_wr(REG_PENDING, 16'h0001);
    cyc(1);
    chk("w1c_irq_low", {15'h0000, irq}, 16'h0000);

    // Debounce: P=9, T=3.
    reg_wr(REG_DEB_CFG, 16'h3009);
    gpio[0] = 1'b1;
    cyc(3);
    gpio[0] = 1'b0;
    cyc(40);
    chk("glitch_level", level, 16'h0000);
    reg_rd(REG_PENDING, rv);
    chk("glitch_pending", rv, 16'h0000);
    gpio[0] = 1'b1;
    t_lvl = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (level[0] && t_lvl < 0) t_lvl = k;
    end
    chk("deb_level_high", level, 16'h0001);
    chk("deb_window", {15'h0000, (t_lvl >= 20 && t_lvl <= 33)}, 16'h0001);
    reg_rd(REG_PENDING, rv);
    chk("deb_rise_pending", rv, 16'h0001);
    gpio[0] = 1'b0;
    cyc(40);
    chk("deb_level_low", level, 16'h0000);
    reg_wr(REG_PENDING, 16'h0001);
    reg_wr(REG_DEB_CFG, 16'h0000);
    reg_wr(REG_IRQ_EN, 16'h0000);

    // Falling-edge only, masked then unmasked.
    reg_wr(REG_RISE_EN, 16'h0000);
    reg_wr(REG_FALL_EN, 16'h0002);
    gpio[1] = 1'b1;
    cyc(6);
    reg_rd(REG_PENDING, rv);
    chk("fall_no_rise", rv, 16'h0000);
    gpio[1] = 1'b0;
    cyc(6);
    reg_rd(REG_PENDING, rv);
    chk("fall_pending", rv, 16'h0002);
    chk("fall_masked_irq", {15'h0000, irq}, 16'h0000);
    reg_wr(REG_IRQ_EN, 16'h0002);
    cyc(1);
    chk("fall_unmask_irq", {15'h0000, irq}, 16'h0001);
    reg_wr(REG_PENDING, 16'h0002);
    reg_wr(REG_IRQ_EN, 16'h0000);

    // Set and W1C of bit 2 in the same cycle.
    reg_wr(REG_RISE_EN, 16'h0004);
    gpio[2] = 1'b1;
    cyc(3);
    addr = REG_PENDING; din = 16'h0004; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    reg_rd(REG_PENDING, rv);
    chk("collision_set_wins", rv, 16'h0004);
    reg_wr(REG_PENDING, 16'h0004);
    reg_rd(REG_PENDING, rv);
    chk("collision_cleared", rv, 16'h0000);

    // All sixteen pins at once.
    gpio = 16'h0000;
    cyc(6);
    reg_wr(REG_FALL_EN, 16'h0000);
    reg_wr(REG_PENDING, 16'hFFFF);
    reg_wr(REG_RISE_EN, 16'hFFFF);
    reg_wr(REG_IRQ_EN, 16'hFFFF);
    gpio = 16'hFFFF;
    cyc(6);
    reg_rd(REG_PENDING, rv);
    chk("all_pending", rv, 16'hFFFF);
    chk("all_irq", {15'h0000, irq}, 16'h0001);
    chk("all_level", level, 16'hFFFF);
    reg_wr(REG_PENDING, 16'h00FF);
    reg_rd(REG_PENDING, rv);
    chk("half_pending", rv, 16'hFF00);
    chk("half_irq", {15'h0000, irq}, 16'h0001);
    reg_wr(REG_PENDING, 16'hFF00);
    cyc(1);
    chk("none_irq", {15'h0000, irq}, 16'h0000);
    reg_rd(REG_PENDING, rv);
    chk("none_pending", rv, 16'h0000);

    // Asynchronous reset mid-operation, then re-qualification of held pins.
    reg_wr(REG_FALL_EN, 16'hFFFF);
    gpio[3] = 1'b0;
    cyc(6);
    chk("pre_rst_irq", {15'h0000, irq}, 16'h0001);
    reg_rd(REG_LEVEL, rv);
    chk("pre_rst_level", rv, 16'hFFF7);
    gpio = 16'hFFFF;
    #10;
    rst = 1'b1;
    #1;
    chk("async_rst_level", level, 16'h0000);
    chk("async_rst_irq", {15'h0000, irq}, 16'h0000);
    chk("async_rst_dout", dout, 16'h0000);
    cyc(3);
    rst = 1'b0;
    reg_wr(REG_RISE_EN, 16'h0001);
    reg_wr(REG_IRQ_EN, 16'h0001);
    cyc(6);
    reg_rd(REG_PENDING, rv);
    chk("post_rst_pending", rv, 16'h0001);
    chk("post_rst_irq", {15'h0000, irq}, 16'h0001);
    chk("post_rst_level", level, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_irq_ctrl.md
Name: gpio_irq_ctrl

Overview:
Parametrised GPIO input and interrupt controller for the slurm16 peripheral bus. It generalises single-pin interrupt input to N channels. Each channel gets a synchroniser, a programmable debouncer, per-channel rising/falling edge selection, sticky pending bits with write-1-to-clear, and a masked, ORed interrupt line to the CPU. It sits between the raw gpio_in pins and the CPU interrupt input, and is mapped as a peripheral register block.

Parameters:
N_CH, 6, number of GPIO input channels (1..16)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEB_BITS, 4, width of per-channel debounce counter; threshold register is DEB_BITS wide
PRESC_BITS, 8, width of shared debounce prescaler

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
GPIO_IN  in  N_CH  raw asynchronous pins
ADDR  in  3  register select
DATA_IN  in  16  write data
DATA_OUT  out  16  read data, registered
WR  in  1  write strobe, one cycle
RD  in  1  read strobe, one cycle
IRQ  out  1  level interrupt to CPU
LEVEL  out  N_CH  debounced pin state

Behaviour:
- Reset (async, RST=1): all registers, sync flops, counters, LEVEL, pending, DATA_OUT and IRQ = 0.
- Register map (bits above N_CH read 0, writes ignored):
  - 0 LEVEL: RO, debounced state.
  - 1 IRQ_EN: RW.
  - 2 RISE_EN: RW.
  - 3 FALL_EN: RW.
  - 4 PENDING: read returns pending; write-1-to-clear.
  - 5 DEB_CFG: RW; [PRESC_BITS-1:0] = prescale P, [15:12] = threshold T (low DEB_BITS used).
  - 6, 7: read 0.
- Read: DATA_OUT updated on the cycle after RD and held until the next RD; one-cycle latency.
- Prescaler: free-running counter. TICK pulses for one cycle every P+1 clocks. P=0 gives a tick every clock. Writing DEB_CFG restarts the prescaler at 0.
- Per channel, sync path: s = GPIO_IN after SYNC_STAGES flops.
- Per channel, debounce when T=0: LEVEL follows s one clock later (bypass).
- Per channel, debounce when T>0:
  - s == LEVEL: count cleared.
  - s != LEVEL and TICK: count increments.
  - When count reaches T, LEVEL <= s and count is cleared in the same cycle.
  - Any glitch shorter than T consecutive ticks is rejected.
  - count saturates and never wraps.
- Edge detect on LEVEL transitions: rise = LEVEL 0->1 with RISE_EN; fall = LEVEL 1->0 with FALL_EN. Either event sets pending the cycle after the LEVEL change.
- Pending is set regardless of IRQ_EN, so masked events are still latched.
- Set/clear collision: if a set and a W1C hit the same bit in the same cycle, set wins.
- IRQ is registered: IRQ = |(pending & IRQ_EN), one cycle after pending or IRQ_EN changes.
- Changing RISE_EN/FALL_EN does not generate events and does not alter existing pending bits.
- Total pin-to-IRQ latency with T=0: SYNC_STAGES + 3 clocks.
- Reset asserted mid-debounce: counter and LEVEL are lost. After release, LEVEL re-qualifies from 0 normally. A pin held high therefore produces a rising event once qualified, if RISE_EN is set.

Decomposition:
- Package gpio_irq_pkg holds:
  - register address constants REG_LEVEL..REG_DEB_CFG;
  - DEB_CFG field positions;
  - read-as-zero mask helper.
- Sub-module gpio_deb_chan, one per channel via generate. It contains the synchroniser, debounce counter, LEVEL flop and rise/fall pulse outputs, and takes TICK, T, RISE_EN and FALL_EN bits as inputs.
- Top level holds the prescaler, register file, pending logic, IRQ and read mux.

Test Plan:
- Reset, then read all regs -> every read returns 0x0000 and IRQ=0. Assert RST mid-operation -> all outputs 0 immediately, without waiting for a clock edge.
- T=0, RISE_EN=1, IRQ_EN=1, pulse GPIO_IN[0] high -> PENDING=0x0001; IRQ=1 exactly 5 clocks after the sampled edge. Write 0x0001 to PENDING -> IRQ=0 next cycle.
- P=9, T=3 at 10 MHz, 300 ns glitch on pin 0 -> no LEVEL change, PENDING=0. A 5000 ns high level -> LEVEL[0]=1 after 3 ticks (~3 us) and a rise event.
- FALL_EN=0x0002, RISE_EN=0, toggle pin 1 high then low -> only the falling edge sets PENDING bit 1. With IRQ_EN=0: PENDING=0x0002 and IRQ stays 0; then setting IRQ_EN=0x0002 -> IRQ=1.
- Rise event on pin 2 in the same cycle as a W1C of bit 2 -> PENDING bit 2 remains 1.
- N_CH=16, all pins edge simultaneously with all enables set -> PENDING=0xFFFF. W1C 0x00FF -> 0xFF00; IRQ stays 1 until 0xFF00 is cleared.
